// File: rtl/exec_muldiv_if.sv
// Execute-stage bundle between the pipeline and the iterative mul/div unit.
// The pipeline side drives the operation request and the flush.
// The unit side returns the result, the done pulse and the stall request.
interface exec_muldiv_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  i_start;
  logic [2:0]            i_op;
  logic [DATA_WIDTH-1:0] i_rs1_data;
  logic [DATA_WIDTH-1:0] i_rs2_data;
  logic                  i_flushE;
  logic [DATA_WIDTH-1:0] o_result;
  logic                  o_done;
  logic                  o_busy;

  modport master (
    output i_start, i_op, i_rs1_data, i_rs2_data, i_flushE,
    input  o_result, o_done, o_busy
  );

  modport slave (
    input  i_start, i_op, i_rs1_data, i_rs2_data, i_flushE,
    output o_result, o_done, o_busy
  );
endinterface

// File: rtl/exec_muldiv.sv
// Iterative RV64M multiply/divide unit for the execute stage.
// Operands are latched as magnitudes together with a result-sign flag.
// Each CALC edge then performs one shift-add (multiply) or one restoring
// shift-subtract (divide) step. After the last step, one extra CALC edge
// applies the sign fix-up and loads o_result. The DONE state raises o_done
// for a single cycle.
module exec_muldiv #(
  parameter int DATA_WIDTH = 64
) (
  input  logic          i_clk,
  input  logic          i_arstn,
  exec_muldiv_if.slave  bus
);
  localparam int W = DATA_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

  logic [1:0]     r_state;
  logic [6:0]     r_cnt;
  logic [2:0]     r_op;
  logic           r_neg;
  logic [W-1:0]   r_opnd;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_result;

  logic           w_accept;
  logic           w_aSigned;
  logic           w_bSigned;
  logic           w_aNeg;
  logic           w_bNeg;
  logic [W-1:0]   w_aMag;
  logic [W-1:0]   w_bMag;
  logic           w_isDiv;
  logic           w_isRem;
  logic           w_divZero;
  logic           w_ovf;
  logic           w_special;
  logic [W-1:0]   w_specialResult;
  logic [W:0]     w_mulSum;
  logic [2*W-1:0] w_mulNext;
  logic [W:0]     w_remSh;
  logic [W:0]     w_diff;
  logic           w_qBit;
  logic [2*W-1:0] w_divNext;
  logic [2*W-1:0] w_accNext;
  logic [2*W-1:0] w_prodFix;
  logic [W-1:0]   w_quoFix;
  logic [W-1:0]   w_remFix;
  logic [W-1:0]   w_final;

  assign w_accept  = (r_state == S_IDLE) & bus.i_start & ~bus.i_flushE;

  // MUL's low half does not depend on signedness, so it runs unsigned.
  assign w_aSigned = (bus.i_op == OP_MULH) | (bus.i_op == OP_MULHSU) |
                     (bus.i_op == OP_DIV)  | (bus.i_op == OP_REM);
  assign w_bSigned = (bus.i_op == OP_MULH) | (bus.i_op == OP_DIV) |
                     (bus.i_op == OP_REM);
  assign w_aNeg    = w_aSigned & bus.i_rs1_data[W-1];
  assign w_bNeg    = w_bSigned & bus.i_rs2_data[W-1];
  assign w_aMag    = w_aNeg ? -bus.i_rs1_data : bus.i_rs1_data;
  assign w_bMag    = w_bNeg ? -bus.i_rs2_data : bus.i_rs2_data;

  assign w_isDiv   = bus.i_op[2];
  assign w_isRem   = bus.i_op[2] & bus.i_op[1];
  assign w_divZero = (bus.i_rs2_data == '0);
  assign w_ovf     = w_isDiv & ~bus.i_op[0] & (bus.i_rs1_data == MIN_INT) &
                     (bus.i_rs2_data == '1);
  assign w_special = w_isDiv & (w_divZero | w_ovf);

  // Result for divisions that bypass iteration: divide by zero or signed overflow.
  always_comb begin
    w_specialResult = '0;
    if (w_divZero) begin
      w_specialResult = w_isRem ? bus.i_rs1_data : '1;
    end else begin
      w_specialResult = w_isRem ? '0 : MIN_INT;
    end
  end

  // Multiply step: r_acc holds {partial high, remaining multiplier bits}.
  assign w_mulSum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mulNext = {w_mulSum, r_acc[W-1:1]};

  // Divide step: r_acc holds {partial remainder, dividend/quotient bits}.
  assign w_remSh   = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_diff    = w_remSh - {1'b0, r_opnd};
  assign w_qBit    = ~w_diff[W];
  assign w_divNext = {(w_qBit ? w_diff[W-1:0] : w_remSh[W-1:0]), r_acc[W-2:0], w_qBit};

  assign w_accNext = r_op[2] ? w_divNext : w_mulNext;

  // Sign fix-up and result selection from the finished accumulator.
  always_comb begin
    w_prodFix = r_neg ? -r_acc : r_acc;
    w_quoFix  = r_neg ? -r_acc[W-1:0] : r_acc[W-1:0];
    w_remFix  = r_neg ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
    w_final   = '0;
    case (r_op)
      OP_MUL:                       w_final = w_prodFix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prodFix[2*W-1:W];
      OP_DIV, OP_DIVU:              w_final = w_quoFix;
      OP_REM, OP_REMU:              w_final = w_remFix;
      default:                      w_final = '0;
    endcase
  end

  // Control FSM plus datapath registers. A flush in CALC or DONE drops back to IDLE untouched.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= bus.i_op;
            r_neg <= w_isRem ? w_aNeg : (w_aNeg ^ w_bNeg);
            r_cnt <= '0;
            if (w_special) begin
              r_result <= w_specialResult;
              r_state  <= S_DONE;
            end else begin
              r_acc   <= w_isDiv ? {{W{1'b0}}, w_aMag} : {{W{1'b0}}, w_bMag};
              r_opnd  <= w_isDiv ? w_bMag : w_aMag;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (bus.i_flushE) begin
            r_state <= S_IDLE;
          end else if (r_cnt == 7'(W)) begin
            r_result <= w_final;
            r_state  <= S_DONE;
          end else begin
            r_acc <= w_accNext;
            r_cnt <= r_cnt + 7'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_result = r_result;
  assign bus.o_done   = (r_state == S_DONE);
  // Stall is held off during reset so a pending i_start cannot freeze the pipeline.
  assign bus.o_busy   = i_arstn & (((r_state == S_IDLE) & bus.i_start & ~bus.i_flushE) |
                                   (r_state == S_CALC));
endmodule

// File: tb/tb_exec_muldiv.sv
// Directed testbench for exec_muldiv.
// A table of operations with hand-computed results and latencies is
// followed by hand-written flush and reset sequences.
module tb_exec_muldiv;
  logic clk = 1'b0;
  logic arstn;
  int   totalChecks = 0;
  int   badChecks   = 0;

  localparam int LAT_NORMAL  = 66;
  localparam int LAT_SPECIAL = 1;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] expRes;
    int          expLat;
  } vec_t;

  vec_t vecs[18];

  exec_muldiv_if #(.DATA_WIDTH(64)) bus();

  exec_muldiv #(.DATA_WIDTH(64)) dut (
    .i_clk   (clk),
    .i_arstn (arstn),
    .bus     (bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case a sequence wedges outside its own bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: actual=0x%h required=0x%h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and count edges from the accepting edge until o_done.
  // Edge 1 is the accepting edge; a normal op then needs 64 step edges plus one
  // fix-up edge, so o_done appears after edge 66 with o_busy high in the 65
  // CALC cycles in between.
  task automatic applyStimulus(input string name, input logic [2:0] op,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] expRes, input int expLat);
    int edges;
    int busyCnt;
    bus.i_op       = op;
    bus.i_rs1_data = a;
    bus.i_rs2_data = b;
    bus.i_flushE   = 1'b0;
    bus.i_start    = 1'b1;
    #2;
    checkOutput({name, "/busy_start"}, 64'(bus.o_busy), 64'd1);
    nextCycle();
    bus.i_start = 1'b0;
    edges   = 1;
    busyCnt = 0;
    while (bus.o_done !== 1'b1 && edges < 200) begin
      if (bus.o_busy === 1'b1) busyCnt++;
      nextCycle();
      edges++;
    end
    checkOutput({name, "/latency"}, 64'(edges), 64'(expLat));
    checkOutput({name, "/result"}, bus.o_result, expRes);
    checkOutput({name, "/busy_cycles"}, 64'(busyCnt), 64'(expLat - 1));
    checkOutput({name, "/busy_in_done"}, 64'(bus.o_busy), 64'd0);
    nextCycle();
    checkOutput({name, "/done_pulse"}, 64'(bus.o_done), 64'd0);
    checkOutput({name, "/result_hold"}, bus.o_result, expRes);
  endtask

  initial begin
    vecs[0]  = '{"mul_7_m3",     3'd0, 64'd7,                  64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, LAT_NORMAL};
    vecs[1]  = '{"mulhu_ones",   3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, LAT_NORMAL};
    vecs[2]  = '{"mulh_ones",    3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                  LAT_NORMAL};
    vecs[3]  = '{"mulhsu_m1_2",  3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, LAT_NORMAL};
    vecs[4]  = '{"mulh_min_2",   3'd1, 64'h8000_0000_0000_0000, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, LAT_NORMAL};
    vecs[5]  = '{"mul_2p32_sq",  3'd0, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'd0,                  LAT_NORMAL};
    vecs[6]  = '{"mulhu_2p32",   3'd3, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'd1,                  LAT_NORMAL};
    vecs[7]  = '{"div_m7_2",     3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFD, LAT_NORMAL};
    vecs[8]  = '{"rem_m7_2",     3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, LAT_NORMAL};
    vecs[9]  = '{"divu_100_7",   3'd5, 64'd100,                64'd7,                  64'd14,                 LAT_NORMAL};
    vecs[10] = '{"remu_100_7",   3'd7, 64'd100,                64'd7,                  64'd2,                  LAT_NORMAL};
    vecs[11] = '{"div_7_m2",     3'd4, 64'd7,                  64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, LAT_NORMAL};
    vecs[12] = '{"rem_7_m2",     3'd6, 64'd7,                  64'hFFFF_FFFF_FFFF_FFFE, 64'd1,                  LAT_NORMAL};
    vecs[13] = '{"divu_ones",    3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  LAT_NORMAL};
    vecs[14] = '{"div_by_zero",  3'd4, 64'd5,                  64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, LAT_SPECIAL};
    vecs[15] = '{"rem_ovf",      3'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                  LAT_SPECIAL};
    vecs[16] = '{"div_ovf",      3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, LAT_SPECIAL};
    vecs[17] = '{"remu_by_zero", 3'd7, 64'h1234,               64'd0,                  64'h1234,               LAT_SPECIAL};

    // Reset with a pending start: no stall, outputs cleared.
    arstn          = 1'b0;
    bus.i_start    = 1'b1;
    bus.i_op       = 3'd4;
    bus.i_rs1_data = 64'd5;
    bus.i_rs2_data = 64'd0;
    bus.i_flushE   = 1'b0;
    #3;
    checkOutput("reset/busy", 64'(bus.o_busy), 64'd0);
    checkOutput("reset/done", 64'(bus.o_done), 64'd0);
    checkOutput("reset/result", bus.o_result, 64'd0);
    nextCycle();
    checkOutput("reset/edge_done", 64'(bus.o_done), 64'd0);
    arstn       = 1'b1;
    bus.i_start = 1'b0;
    nextCycle();
    checkOutput("reset/no_accept", 64'(bus.o_done), 64'd0);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].expRes, vecs[i].expLat);
    end

    // Flush a DIVU after 30 steps, then start a MUL on the very next cycle.
    bus.i_op       = 3'd5;
    bus.i_rs1_data = 64'd1000;
    bus.i_rs2_data = 64'd3;
    bus.i_start    = 1'b1;
    nextCycle();
    bus.i_start = 1'b0;
    repeat (30) nextCycle();
    bus.i_flushE = 1'b1;
    nextCycle();
    bus.i_flushE = 1'b0;
    checkOutput("flush/busy", 64'(bus.o_busy), 64'd0);
    checkOutput("flush/done", 64'(bus.o_done), 64'd0);
    checkOutput("flush/result_kept", bus.o_result, 64'h1234);
    applyStimulus("mul_5_6_after_flush", 3'd0, 64'd5, 64'd6, 64'd30, LAT_NORMAL);

    // Flush together with start in IDLE: a divide-by-zero would finish in one edge if accepted.
    bus.i_op       = 3'd4;
    bus.i_rs1_data = 64'd9;
    bus.i_rs2_data = 64'd0;
    bus.i_start    = 1'b1;
    bus.i_flushE   = 1'b1;
    #2;
    checkOutput("idle_flush/busy", 64'(bus.o_busy), 64'd0);
    nextCycle();
    bus.i_start  = 1'b0;
    bus.i_flushE = 1'b0;
    checkOutput("idle_flush/done", 64'(bus.o_done), 64'd0);
    checkOutput("idle_flush/result", bus.o_result, 64'd30);
    nextCycle();
    checkOutput("idle_flush/done_later", 64'(bus.o_done), 64'd0);

    // Reset in the middle of CALC, with i_start held high to check the stall is suppressed.
    bus.i_op       = 3'd0;
    bus.i_rs1_data = 64'd9;
    bus.i_rs2_data = 64'd9;
    bus.i_start    = 1'b1;
    nextCycle();
    bus.i_start = 1'b0;
    repeat (10) nextCycle();
    bus.i_start = 1'b1;
    #2;
    arstn = 1'b0;
    #1;
    checkOutput("mid_reset/busy", 64'(bus.o_busy), 64'd0);
    checkOutput("mid_reset/result", bus.o_result, 64'd0);
    checkOutput("mid_reset/done", 64'(bus.o_done), 64'd0);
    nextCycle();
    checkOutput("mid_reset/busy_held", 64'(bus.o_busy), 64'd0);
    arstn = 1'b1;
    applyStimulus("mul_2_3_after_reset", 3'd0, 64'd2, 64'd3, 64'd6, LAT_NORMAL);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end
endmodule
